// File: rtl/aes_pkg.sv
// Shared AES definitions for the sequential InvMixColumns block.
// Holds the FSM states, column geometry and GF(2^8) helpers.
package aes_pkg;

    localparam int NUM_COLS = 4;
    localparam int COL_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Multiply by x modulo the AES polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; enough for the 0x09/0x0b/0x0d/0x0e taps.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Column 0 sits in the most significant word of the 128-bit state.
    function automatic int col_lsb(input logic [1:0] idx);
        return (NUM_COLS - 1 - int'(idx)) * COL_W;
    endfunction

endpackage

// File: rtl/inv_mix_col_seq_if.sv
// Input/output handshake bundle of the sequential InvMixColumns block.
interface inv_mix_col_seq_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_bypass, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_bypass, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/InvWordMixColumns.sv
// InvMixColumns on a single 32-bit column; byte 0 is the most significant byte.
module InvWordMixColumns
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] word_i,
    output logic [COL_W-1:0] word_o
);

    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;

    assign {a0, a1, a2, a3} = word_i;

    assign word_o[31:24] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
    assign word_o[23:16] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
    assign word_o[15:8]  = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
    assign word_o[7:0]   = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);

endmodule

// File: rtl/inv_mix_col_seq.sv
// Sequential InvMixColumns: captures a state, transforms COLS_PER_CYCLE columns
// per cycle into a result register, then holds the result until it is taken.
module inv_mix_col_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    inv_mix_col_seq_if.slave  bus,
    output logic              busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("inv_mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_IDX = 2'(NUM_COLS - COLS_PER_CYCLE);

    state_e       state_q;
    state_e       state_d;
    logic [1:0]   col_idx_q;
    logic [1:0]   col_idx_d;
    logic [127:0] data_q;
    logic [127:0] data_d;
    logic         bypass_q;
    logic         bypass_d;
    logic [127:0] res_q;
    logic [127:0] res_d;
    logic         in_ready;
    logic         capture;

    logic [1:0]       col_sel [COLS_PER_CYCLE];
    logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
        assign col_sel[gi] = col_idx_q + 2'(gi);
        assign col_in[gi]  = data_q[col_lsb(col_sel[gi]) +: COL_W];

        InvWordMixColumns u_col (
            .word_i (col_in[gi]),
            .word_o (col_out[gi])
        );
    end

    assign in_ready      = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign capture       = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = res_q;
    assign busy          = (state_q == BUSY);

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        data_d    = data_q;
        bypass_d  = bypass_q;
        res_d     = res_q;

        case (state_q)
            BUSY: begin
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    res_d[col_lsb(col_sel[i]) +: COL_W] = bypass_q ? col_in[i] : col_out[i];
                end
                // Hold col_idx on the final step so it only returns to 0 on a capture.
                if (col_idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    col_idx_d = col_idx_q + COL_STEP;
                end
            end
            DONE: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = IDLE;
                end
            end
            IDLE: ;
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d   = BUSY;
            col_idx_d = 2'd0;
            data_d    = bus.in_data;
            bypass_d  = bus.in_bypass;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_idx_q <= 2'd0;
            data_q    <= '0;
            bypass_q  <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            data_q    <= data_d;
            bypass_q  <= bypass_d;
            res_q     <= res_d;
        end
    end

endmodule

// File: tb/tb_inv_mix_col_seq.sv
// Directed bench for inv_mix_col_seq at one, two and four columns per cycle.
module tb_inv_mix_col_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_mix_col_seq_if if1 ();
    inv_mix_col_seq_if if2 ();
    inv_mix_col_seq_if if4 ();
    logic busy1;
    logic busy2;
    logic busy4;

    inv_mix_col_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1), .busy(busy1));
    inv_mix_col_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2), .busy(busy2));
    inv_mix_col_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4), .busy(busy4));

    typedef struct {
        logic [127:0] din;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_ready1();
        for (int g = 0; g < 50 && !if1.in_ready; g++) begin
            @(posedge clk);
            #1;
        end
        chk1("in_ready_before_accept", if1.in_ready, 1'b1);
    endtask

    // One transfer through the single-column instance, with junk offered while busy.
    task automatic run_vec1(input int idx);
        int lat;
        wait_ready1();
        if1.in_valid  = 1'b1;
        if1.in_data   = vecs[idx].din;
        if1.in_bypass = vecs[idx].byp;
        @(posedge clk);
        lat = 1;
        #1;
        chk1("busy_after_accept", busy1, 1'b1);
        chk1("in_ready_in_busy", if1.in_ready, 1'b0);
        if1.in_data   = ~vecs[idx].din;
        if1.in_bypass = ~vecs[idx].byp;
        while (!if1.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if1.in_valid = 1'b0;
        end
        chk1("out_valid_seen", if1.out_valid, 1'b1);
        chk_int("latency_n1", lat, 5);
        chk("out_data_n1", if1.out_data, vecs[idx].exp);
        $display("txn n1 vec%0d: in=%h byp=%b out=%h lat=%0d", idx, vecs[idx].din, vecs[idx].byp, if1.out_data, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel [3];
        int lat2;
        int lat4;
        int cnt;
        logic [127:0] d2;
        logic [127:0] d4;

        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0, 128'hdb135345_f20a225c_01010101_d4d4d4d5};
        vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6};
        vecs[2] = '{128'h4d7ebdf8_c6c6c6c6_00000000_01010101, 1'b0, 128'h2d26314c_c6c6c6c6_00000000_01010101};
        vecs[3] = '{128'h01010101_4d7ebdf8_d5d5d7d6_8e4da1bc, 1'b0, 128'h01010101_2d26314c_d4d4d4d5_db135345};
        vecs[4] = '{128'hd5d5d7d6_8e4da1bc_ffffffff_9fdc589d, 1'b0, 128'hd4d4d4d5_db135345_ffffffff_f20a225c};
        sel = '{0, 2, 1};

        if1.in_valid = 1'b0; if1.in_data = '0; if1.in_bypass = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.in_bypass = 1'b0; if2.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.in_bypass = 1'b0; if4.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", if1.out_valid, 1'b0);
        chk1("rst_busy", busy1, 1'b0);
        chk("rst_out_data", if1.out_data, 128'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk1("in_ready_after_rst", if1.in_ready, 1'b1);

        // Table of single transfers
        for (int v = 0; v < 5; v++) begin
            run_vec1(v);
            @(posedge clk);
            #1;
            chk1("out_valid_drop", if1.out_valid, 1'b0);
        end

        // Consumer stall in DONE
        if1.out_ready = 1'b0;
        run_vec1(3);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk1("stall_out_valid", if1.out_valid, 1'b1);
            chk("stall_out_data", if1.out_data, vecs[3].exp);
            chk1("stall_in_ready", if1.in_ready, 1'b0);
        end
        if1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1("release_out_valid", if1.out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk1("release_single", if1.out_valid, 1'b0);
        $display("txn n1 stall: released after 3 stalled cycles");

        // Back-to-back with in_valid held
        wait_ready1();
        if1.in_valid  = 1'b1;
        if1.in_data   = vecs[0].din;
        if1.in_bypass = 1'b0;
        @(posedge clk);
        #1;
        if1.in_data = vecs[2].din;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) if1.in_valid = 1'b0;
            chk1("b2b_out_valid", if1.out_valid, (k == 4 || k == 9));
            chk1("b2b_busy", busy1, (k <= 3) || (k >= 5 && k <= 8));
            if (k == 4) begin
                chk("b2b_data0", if1.out_data, vecs[0].exp);
                chk1("b2b_in_ready", if1.in_ready, 1'b1);
                $display("txn n1 b2b first: out=%h", if1.out_data);
            end
            if (k == 9) begin
                chk("b2b_data1", if1.out_data, vecs[2].exp);
                $display("txn n1 b2b second: out=%h", if1.out_data);
            end
        end

        // Reset on the second BUSY cycle
        wait_ready1();
        if1.in_valid = 1'b1;
        if1.in_data  = vecs[0].din;
        @(posedge clk);
        #1;
        if1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("midbusy_rst_out_valid", if1.out_valid, 1'b0);
        chk("midbusy_rst_out_data", if1.out_data, 128'h0);
        chk1("midbusy_rst_busy", busy1, 1'b0);
        chk1("midbusy_rst_in_ready", if1.in_ready, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk1("midbusy_no_out_valid", if1.out_valid, 1'b0);
        end
        $display("txn n1 reset mid-BUSY: operation discarded");

        // Reset while holding a result in DONE
        if1.out_ready = 1'b0;
        run_vec1(4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if1.out_ready = 1'b1;
        chk1("middone_rst_out_valid", if1.out_valid, 1'b0);
        chk("middone_rst_out_data", if1.out_data, 128'h0);
        $display("txn n1 reset mid-DONE: result discarded");

        // Wider datapaths
        for (int s = 0; s < 3; s++) begin
            chk1("n2_in_ready", if2.in_ready, 1'b1);
            chk1("n4_in_ready", if4.in_ready, 1'b1);
            if2.in_valid = 1'b1; if2.in_data = vecs[sel[s]].din; if2.in_bypass = vecs[sel[s]].byp;
            if4.in_valid = 1'b1; if4.in_data = vecs[sel[s]].din; if4.in_bypass = vecs[sel[s]].byp;
            @(posedge clk);
            cnt  = 1;
            lat2 = 0;
            lat4 = 0;
            d2   = '0;
            d4   = '0;
            #1;
            if2.in_valid = 1'b0; if2.in_data = ~vecs[sel[s]].din;
            if4.in_valid = 1'b0; if4.in_data = ~vecs[sel[s]].din;
            for (int g = 0; g < 20 && (lat2 == 0 || lat4 == 0); g++) begin
                if (if2.out_valid && lat2 == 0) begin lat2 = cnt; d2 = if2.out_data; end
                if (if4.out_valid && lat4 == 0) begin lat4 = cnt; d4 = if4.out_data; end
                if (lat2 == 0 || lat4 == 0) begin
                    @(posedge clk);
                    cnt++;
                    #1;
                end
            end
            chk_int("latency_n2", lat2, 3);
            chk_int("latency_n4", lat4, 2);
            chk("out_data_n2", d2, vecs[sel[s]].exp);
            chk("out_data_n4", d4, vecs[sel[s]].exp);
            $display("txn n2/n4 vec%0d: out2=%h lat2=%0d out4=%h lat4=%0d", sel[s], d2, lat2, d4, lat4);
            repeat (2) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_mix_col_seq.md
INV_MIX_COL_SEQ -- requirements
Module: inv_mix_col_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning columns transformed per cycle; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning in_data/in_bypass are valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts a state this cycle.
REQ-006 SHALL have port in_data, input, 128, AES state; column 0 = [127:96], column 3 = [31:0].
REQ-007 SHALL have port in_bypass, input, 1, meaning the state passes unchanged (final round); sampled with in_data.
REQ-008 SHALL have port out_valid, output, 1, meaning out_data holds a completed result.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-010 SHALL have port out_data, output, 128, InvMixColumns(in_data), or in_data if bypassed; same column mapping as in_data.
REQ-011 SHALL have port busy, output, 1, high when state is BUSY.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL complete an input transfer on a rising edge where in_valid && in_ready, capturing in_data, in_bypass, col_idx=0, next state BUSY.
REQ-014 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), combinationally.
REQ-015 SHALL transform, in each BUSY cycle, columns col_idx .. col_idx+COLS_PER_CYCLE-1 of the captured state into the result register, then advance col_idx by COLS_PER_CYCLE.
REQ-016 SHALL leave BUSY for DONE on the edge that writes column 3; BUSY lasts exactly 4/COLS_PER_CYCLE cycles.
REQ-017 SHALL assert out_valid on the first cycle after that edge; accept-edge to out_valid latency is 4/COLS_PER_CYCLE+1 edges, independent of in_bypass.
REQ-018 SHALL write the captured column unchanged, when bypass is captured, on the same schedule.
REQ-019 SHALL hold out_valid and out_data stable while out_valid && !out_ready.
REQ-020 SHALL go from DONE with out_ready && !in_valid to IDLE, deasserting out_valid next cycle.
REQ-021 SHALL, in DONE with out_ready && in_valid, complete both transfers on the same edge and go directly to BUSY (zero-bubble back-to-back).
REQ-022 SHALL ignore in_valid in BUSY (in_ready=0); in_data may change without effect.
REQ-023 SHALL count col_idx 2 bits wide; it wraps to 0 only via a new capture, never by overflow.
REQ-024 SHALL apply each column's transform to that column alone (no cross-column mixing); per-byte GF(2^8) arithmetic per FIPS-197 with polynomial 0x11B.

Reset
REQ-025 SHALL, with rst high at a rising edge, set state=IDLE, col_idx=0, out_valid=0, busy=0, out_data=0, captured state=0, captured bypass=0.
REQ-026 SHALL give rst priority over all handshakes; rst mid-BUSY or mid-DONE discards the operation and emits no out_valid.
REQ-027 SHALL drive in_ready=1 on the first cycle after rst deasserts.

Structure
REQ-028 SHALL place the FSM state enum and constants NUM_COLS=4 and COL_W=32 in shared package aes_pkg.
REQ-029 SHALL instantiate the existing InvWordMixColumns sub-module COLS_PER_CYCLE times as the sole datapath; column select is a mux on col_idx.
REQ-030 SHALL contain no combinational path from in_data to out_data; out_data comes from the result register only.

Verification
REQ-031 SHALL cover: COLS_PER_CYCLE=1, in_data=8e4da1bc_9fdc589d_01010101_d5d5d7d6, bypass=0, out_ready=1 -> out_data=db135345_f20a225c_01010101_d4d4d4d5, out_valid 5 edges after accept.
REQ-032 SHALL cover: same input with in_bypass=1 -> out_data equals in_data, same latency.
REQ-033 SHALL cover: out_ready=0 for 3 cycles in DONE -> out_valid/out_data stable, in_ready=0; release -> one transfer only.
REQ-034 SHALL cover: two back-to-back inputs, in_valid held, out_ready=1 -> results in order, period 5 cycles, no IDLE cycle.
REQ-035 SHALL cover: rst pulsed on 2nd BUSY cycle -> no out_valid, out_data=0, in_ready=1 next cycle.
REQ-036 SHALL cover: COLS_PER_CYCLE=4 and 2 with vector of REQ-031 -> identical out_data, latencies 2 and 3.
